// File: rtl/d_sram_to_sramlike_bridge_pkg.sv
// Shared definitions for the data-side SRAM to sram-like bridge.
//
// Contents:
//   state_t     - bridge FSM encoding (S_REQ / S_WAIT / S_DONE)
//   SIZE_*      - sram-like transfer size codes (byte / half / word)
//   wen_size()  - byte-write-enable pattern to transfer size
package d_sram_to_sramlike_bridge_pkg;

  typedef enum logic [1:0] {
    S_REQ  = 2'd0,  // issuing a request, or idle
    S_WAIT = 2'd1,  // address accepted, awaiting data_ok
    S_DONE = 2'd2   // result held until the pipeline advances
  } state_t;

  localparam logic [1:0] SIZE_B = 2'd0;
  localparam logic [1:0] SIZE_H = 2'd1;
  localparam logic [1:0] SIZE_W = 2'd2;

  // Reads (0000) are always fetched as whole words. Write patterns the ISA
  // never produces also fall back to a word; no error is raised for them.
  function automatic logic [1:0] wen_size(input logic [3:0] wen);
    logic [1:0] size;
    case (wen)
      4'b0001, 4'b0010, 4'b0100, 4'b1000: size = SIZE_B;
      4'b0011, 4'b1100:                   size = SIZE_H;
      default:                            size = SIZE_W;
    endcase
    return size;
  endfunction

endpackage

// File: rtl/d_sram_to_sramlike_bridge_wen_to_size.sv
// Combinational decoder from a core byte-write-enable pattern to the
// sram-like request attributes. Also used by the instruction-side bridge,
// which ties wen to 0000 and therefore always gets word-sized, word-aligned
// requests.
//
// Ports:
//   wen       in  4       byte write enables, 0000 = read
//   addr      in  ADDR_W  core byte address
//   wr        out 1       1 = write
//   size      out 2       SIZE_B / SIZE_H / SIZE_W
//   addr_out  out ADDR_W  request address (word-aligned for reads)
module d_sram_to_sramlike_bridge_wen_to_size
  import d_sram_to_sramlike_bridge_pkg::*;
#(
  parameter int ADDR_W = 32
) (
  input  logic [3:0]        wen,
  input  logic [ADDR_W-1:0] addr,
  output logic              wr,
  output logic [1:0]        size,
  output logic [ADDR_W-1:0] addr_out
);

  assign wr   = |wen;
  assign size = wen_size(wen);

  // Reads fetch the whole word; the core picks its byte/half lane itself.
  // Writes keep the byte address so the slave sees the exact lane.
  assign addr_out = wr ? addr : {addr[ADDR_W-1:2], 2'b00};

endmodule

// File: rtl/d_sram_to_sramlike_bridge.sv
// Data-side bridge: turns each core SRAM-port access into exactly one
// sram-like master transaction, stalls the core until data_ok, and holds
// the result while the rest of the pipeline is stalled so the same M-stage
// access is never issued twice.
//
// Handshake: a request is transferred in a cycle where data_req and
// data_addr_ok are both high; data_ok completes it no earlier than the
// following cycle. At most one transaction is outstanding, and data_req
// stays low from acceptance until the pipeline has advanced past the access.
//
// Ports:
//   clk, rst                 clock (rising edge), async active-high reset
//   data_sram_en/wen/addr/wdata   core access (M stage)
//   data_sram_rdata          registered response data to the core
//   d_stall                  stall request to the core
//   longest_stall            global pipeline stall from the core
//   data_req/wr/size/addr/wdata   sram-like request
//   data_addr_ok/data_ok/rdata    sram-like response
//
// The FSM state is the internal signal `state` (type state_t).
module d_sram_to_sramlike_bridge
  import d_sram_to_sramlike_bridge_pkg::*;
#(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32   // only 32 is supported
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              data_sram_en,
  input  logic [3:0]        data_sram_wen,
  input  logic [ADDR_W-1:0] data_sram_addr,
  input  logic [DATA_W-1:0] data_sram_wdata,
  output logic [DATA_W-1:0] data_sram_rdata,
  output logic              d_stall,
  input  logic              longest_stall,
  output logic              data_req,
  output logic              data_wr,
  output logic [1:0]        data_size,
  output logic [ADDR_W-1:0] data_addr,
  output logic [DATA_W-1:0] data_wdata,
  input  logic              data_addr_ok,
  input  logic              data_data_ok,
  input  logic [DATA_W-1:0] data_rdata
);

  state_t            state;
  state_t            state_next;
  logic [DATA_W-1:0] rdata_r;
  logic              capture;
  logic              req_raw;

  d_sram_to_sramlike_bridge_wen_to_size #(
    .ADDR_W (ADDR_W)
  ) u_wen_to_size (
    .wen      (data_sram_wen),
    .addr     (data_sram_addr),
    .wr       (data_wr),
    .size     (data_size),
    .addr_out (data_addr)
  );

  assign data_wdata = data_sram_wdata;

  // Requests are only raised from S_REQ, which also means longest_stall
  // never reaches data_req combinationally: leaving S_DONE takes a clock.
  assign req_raw = data_sram_en & (state == S_REQ);

  // Gating with rst keeps both outputs low for the whole reset pulse, not
  // just from the point the state register has cleared.
  assign data_req = req_raw & ~rst;
  assign d_stall  = data_sram_en & (state != S_DONE) & ~rst;

  assign data_sram_rdata = rdata_r;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state   <= S_REQ;
      rdata_r <= '0;
    end else begin
      state <= state_next;
      if (capture) begin
        rdata_r <= data_rdata;
      end
    end
  end

  // data_ok is only honoured in S_WAIT; one arriving in S_REQ is a slave
  // protocol violation and is ignored. A flush (en falling) in S_WAIT does
  // not abandon the transaction: it still has to drain through S_DONE.
  always_comb begin
    state_next = state;
    capture    = 1'b0;
    case (state)
      S_REQ: begin
        if (req_raw && data_addr_ok) begin
          state_next = S_WAIT;
        end
      end
      S_WAIT: begin
        if (data_data_ok) begin
          state_next = S_DONE;
          capture    = 1'b1;
        end
      end
      S_DONE: begin
        if (!longest_stall) begin
          state_next = S_REQ;
        end
      end
      default: begin
        state_next = S_REQ;
      end
    endcase
  end

endmodule

// File: tb/tb_d_sram_to_sramlike_bridge.sv
module tb_d_sram_to_sramlike_bridge;
  import d_sram_to_sramlike_bridge_pkg::*;

  // ---------------------------------------------------------------- clock/reset
  logic        clk = 1'b0;
  logic        rst;
  logic        data_sram_en;
  logic [3:0]  data_sram_wen;
  logic [31:0] data_sram_addr;
  logic [31:0] data_sram_wdata;
  logic [31:0] data_sram_rdata;
  logic        d_stall;
  logic        longest_stall;
  logic        data_req;
  logic        data_wr;
  logic [1:0]  data_size;
  logic [31:0] data_addr;
  logic [31:0] data_wdata;
  logic        data_addr_ok;
  logic        data_data_ok;
  logic [31:0] data_rdata;

  always #5 clk = ~clk;

  d_sram_to_sramlike_bridge #(
    .ADDR_W (32),
    .DATA_W (32)
  ) dut (
    .clk             (clk),
    .rst             (rst),
    .data_sram_en    (data_sram_en),
    .data_sram_wen   (data_sram_wen),
    .data_sram_addr  (data_sram_addr),
    .data_sram_wdata (data_sram_wdata),
    .data_sram_rdata (data_sram_rdata),
    .d_stall         (d_stall),
    .longest_stall   (longest_stall),
    .data_req        (data_req),
    .data_wr         (data_wr),
    .data_size       (data_size),
    .data_addr       (data_addr),
    .data_wdata      (data_wdata),
    .data_addr_ok    (data_addr_ok),
    .data_data_ok    (data_data_ok),
    .data_rdata      (data_rdata)
  );

  // ---------------------------------------------------------------- scoreboard
  int          total = 0;
  int          bad   = 0;
  logic [66:0] exp_q[$];      // {wr, size, addr, wdata} per expected request
  logic [31:0] last_rdata;    // value the core must currently see

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // Reference rules for the request attributes.
  function automatic logic [1:0] ref_size(input logic [3:0] wen);
    case (wen)
      4'b0001, 4'b0010, 4'b0100, 4'b1000: return 2'd0;
      4'b0011, 4'b1100:                   return 2'd1;
      default:                            return 2'd2;
    endcase
  endfunction

  function automatic logic [31:0] ref_addr(input logic [3:0] wen, input logic [31:0] a);
    return (wen == 4'b0000) ? {a[31:2], 2'b00} : a;
  endfunction

  // ---------------------------------------------------------------- driver
  // Runs one core access plus the slave side. Called #1 after a rising edge;
  // returns #1 after the rising edge on which the pipeline advances.
  //   a_lat   : request cycles before addr_ok (0 = issue cycle)
  //   d_lat   : extra cycles after the one following addr_ok before data_ok
  //   ls_hold : S_DONE cycles spent under longest_stall
  //   spur    : pulse a bogus data_ok in the first request cycle (a_lat > 0)
  //   flush   : drop data_sram_en the cycle after acceptance
  task automatic run_access(input logic [3:0] wen, input logic [31:0] addr,
                            input logic [31:0] wdata, input logic [31:0] rd,
                            input int a_lat, input int d_lat, input int ls_hold,
                            input bit spur, input bit flush);
    bit          accepted = 0;
    bit          returned = 0;
    bit          retired  = 0;
    bit          data_real;
    int          req_cycles = 0;
    int          wait_cycles = 0;
    int          done_cycles = 0;
    int          stall_cycles = 0;
    int          hs = 0;
    int          cyc = 0;
    logic [66:0] e;

    exp_q.push_back({|wen, ref_size(wen), ref_addr(wen, addr), wdata});
    data_sram_en    = 1'b1;
    data_sram_wen   = wen;
    data_sram_addr  = addr;
    data_sram_wdata = wdata;

    while (!retired && cyc < 200) begin
      if (flush && accepted) data_sram_en = 1'b0;
      longest_stall = (ls_hold > 0) && (done_cycles < ls_hold);
      data_addr_ok  = 1'b0;
      data_data_ok  = 1'b0;
      data_rdata    = $urandom;
      data_real     = 1'b0;
      #1;
      if (!accepted) begin
        if (data_req) begin
          if (req_cycles == a_lat) data_addr_ok = 1'b1;
          else if (spur && req_cycles == 0) data_data_ok = 1'b1;
          req_cycles++;
        end
      end else if (!returned) begin
        if (wait_cycles == d_lat) begin
          data_data_ok = 1'b1;
          data_rdata   = rd;
          data_real    = 1'b1;
        end
        wait_cycles++;
      end

      @(negedge clk);
      check("req", 64'(data_req), 64'(data_sram_en && !accepted));
      check("stall", 64'(d_stall), 64'(data_sram_en && !returned));
      check("rdata", 64'(data_sram_rdata), 64'(last_rdata));
      if (d_stall) stall_cycles++;
      if (data_req && exp_q.size() > 0) begin
        e = exp_q[0];
        check("wr", 64'(data_wr), 64'(e[66]));
        check("size", 64'(data_size), 64'(e[65:64]));
        check("addr", 64'(data_addr), 64'(e[63:32]));
        if (e[66]) check("wdata", 64'(data_wdata), 64'(e[31:0]));
      end
      if (data_req && data_addr_ok) begin
        hs++;
        if (exp_q.size() > 0) e = exp_q.pop_front();
        accepted = 1'b1;
      end
      if (returned) begin
        check("state_done", 64'(dut.state), 64'(S_DONE));
        done_cycles++;
        if (!longest_stall) retired = 1'b1;
      end
      if (data_real) begin
        returned   = 1'b1;
        last_rdata = rd;
      end
      @(posedge clk);
      #1;
      cyc++;
    end

    longest_stall = 1'b0;
    if (!retired) check("timeout", 64'(0), 64'(1));
    check("handshakes", 64'(hs), 64'(1));
    check("req_cycles", 64'(req_cycles), 64'(a_lat + 1));
    if (!flush) check("stall_cycles", 64'(stall_cycles), 64'(a_lat + d_lat + 2));
  endtask

  // ---------------------------------------------------------------- stimulus
  logic [3:0] wen_tab [0:7] = '{4'b0000, 4'b0001, 4'b0010, 4'b0100,
                                4'b1000, 4'b0011, 4'b1100, 4'b1111};
  logic [3:0]  r_wen;
  logic [31:0] r_addr;
  int          r_alat;

  initial begin
    rst             = 1'b1;
    data_sram_en    = 1'b1;
    data_sram_wen   = 4'b0000;
    data_sram_addr  = 32'h8000_0000;
    data_sram_wdata = 32'h0;
    longest_stall   = 1'b0;
    data_addr_ok    = 1'b0;
    data_data_ok    = 1'b0;
    data_rdata      = 32'h0;
    last_rdata      = 32'h0;

    // Reset state: outputs low even with an access pending.
    repeat (2) @(posedge clk);
    #1;
    check("rst_state", 64'(dut.state), 64'(S_REQ));
    check("rst_stall", 64'(d_stall), 64'(0));
    check("rst_req", 64'(data_req), 64'(0));
    check("rst_rdata", 64'(data_sram_rdata), 64'(0));
    @(posedge clk);
    #1;
    rst = 1'b0;

    // lw, best-case latency.
    run_access(4'b0000, 32'h8000_0104, 32'h0, 32'hDEAD_BEEF, 0, 0, 0, 0, 0);
    check("lw_rdata", 64'(data_sram_rdata), 64'(32'hDEAD_BEEF));
    // sb to lane 2.
    run_access(4'b0100, 32'h8000_0012, 32'h00AB_0000, 32'h1111_2222, 0, 1, 0, 0, 0);
    // lh with addr_ok delayed 3 cycles.
    run_access(4'b0000, 32'h8000_0006, 32'h0, 32'h3333_4444, 3, 0, 0, 0, 0);
    // Read completing under a 5-cycle pipeline stall, then an immediate next access.
    run_access(4'b0000, 32'h8000_0200, 32'h0, 32'h5555_6666, 0, 0, 5, 0, 0);
    // Two back-to-back sw.
    run_access(4'b1111, 32'h0000_0010, 32'hCAFE_0010, 32'h0, 0, 0, 0, 0, 0);
    run_access(4'b1111, 32'h0000_0014, 32'hCAFE_0014, 32'h0, 1, 2, 0, 0, 0);
    // Stray data_ok before acceptance, half-word store.
    run_access(4'b1100, 32'h8000_0022, 32'hBEEF_0000, 32'h7777_8888, 2, 1, 0, 1, 0);
    // Flush while waiting for data_ok.
    run_access(4'b0000, 32'h8000_0300, 32'h0, 32'h9999_AAAA, 0, 3, 1, 0, 1);

    // Reset while in S_WAIT: everything drops at once, then a fresh lw.
    data_sram_en   = 1'b1;
    data_sram_wen  = 4'b0000;
    data_sram_addr = 32'h8000_0400;
    data_addr_ok   = 1'b1;
    @(negedge clk);
    check("pre_rst_req", 64'(data_req), 64'(1));
    @(posedge clk);
    #1;
    data_addr_ok = 1'b0;
    check("pre_rst_wait", 64'(dut.state), 64'(S_WAIT));
    #2;
    rst = 1'b1;
    #1;
    check("arst_state", 64'(dut.state), 64'(S_REQ));
    check("arst_stall", 64'(d_stall), 64'(0));
    check("arst_req", 64'(data_req), 64'(0));
    check("arst_rdata", 64'(data_sram_rdata), 64'(0));
    @(posedge clk);
    #1;
    rst        = 1'b0;
    last_rdata = 32'h0;
    run_access(4'b0000, 32'h8000_0400, 32'h0, 32'h1234_5678, 0, 0, 0, 0, 0);

    // Randomised accesses.
    for (int i = 0; i < 40; i++) begin
      r_wen  = ($urandom_range(0, 8) == 8) ? 4'($urandom_range(0, 15))
                                           : wen_tab[$urandom_range(0, 7)];
      r_addr = $urandom;
      r_alat = $urandom_range(0, 3);
      run_access(r_wen, r_addr, $urandom, $urandom, r_alat, $urandom_range(0, 3),
                 ($urandom_range(0, 2) == 0) ? $urandom_range(1, 4) : 0,
                 (r_alat > 0) && ($urandom_range(0, 1) == 1),
                 $urandom_range(0, 7) == 0);
    end

    data_sram_en = 1'b0;
    @(negedge clk);
    check("idle_req", 64'(data_req), 64'(0));
    check("idle_stall", 64'(d_stall), 64'(0));
    check("queue_empty", 64'(exp_q.size()), 64'(0));

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/d_sram_to_sramlike_bridge.md
Name: d_sram_to_sramlike_bridge

Overview:
- Responder for the core's data-side SRAM port (enable / byte-write-enable / address / write data in; read data and stall out).
- Converts each core access into exactly one sram-like master transaction (req/addr_ok/data_ok) toward the AXI interface wrapper.
- Holds the core stalled until data_ok returns.
- Latches the result while any other pipeline stall (longest_stall) is active, so no access is issued twice.

Parameters:
- ADDR_W, 32, address width.
- DATA_W, 32, data width (only 32 is supported).

Ports:
- clk  in  1  clock, rising edge.
- rst  in  1  asynchronous active-high reset.
- data_sram_en  in  1  core access request (M stage).
- data_sram_wen  in  4  byte write enables; 0000 = read.
- data_sram_addr  in  ADDR_W  byte address.
- data_sram_wdata  in  DATA_W  lane-aligned write data.
- data_sram_rdata  out  DATA_W  registered read data returned to the core.
- d_stall  out  1  stall request to the core.
- longest_stall  in  1  global pipeline stall from the core (OR of all stall sources).
- data_req  out  1  sram-like request.
- data_wr  out  1  1 = write.
- data_size  out  2  0 = byte, 1 = half, 2 = word.
- data_addr  out  ADDR_W  request address.
- data_wdata  out  DATA_W  request write data.
- data_addr_ok  in  1  request accepted.
- data_data_ok  in  1  response valid / write done.
- data_rdata  in  DATA_W  response data.

Behaviour:
- Clock and reset: one clock clk. rst is asynchronous, active-high.
- Reset values: state = S_REQ; rdata_r = 0; d_stall = 0; data_req = 0.
- States:
  - S_REQ: issuing or idle.
  - S_WAIT: address accepted, awaiting data_ok.
  - S_DONE: transaction complete, waiting for the pipeline to advance.
- Request outputs (combinational):
  - data_req = data_sram_en & (state == S_REQ).
  - data_wr = |data_sram_wen.
- data_size from wen:
  - 0001/0010/0100/1000 -> 0.
  - 0011/1100 -> 1.
  - 1111 -> 2.
  - 0000 -> 2.
  - Any other pattern -> 2 (undefined by ISA; no error signalled).
- data_addr:
  - Reads: {addr[ADDR_W-1:2], 2'b00}. The core extracts byte/half lanes from the word.
  - Writes: data_sram_addr unmodified.
- data_wdata = data_sram_wdata.
- Transitions:
  - S_REQ -> S_WAIT when data_req & data_addr_ok.
  - S_WAIT -> S_DONE when data_data_ok; capture rdata_r <= data_rdata (reads and writes alike).
  - S_DONE -> S_REQ when !longest_stall.
  - Otherwise hold.
- d_stall = data_sram_en & (state != S_DONE). d_stall is 0 when data_sram_en = 0.
- data_sram_rdata = rdata_r. It stays valid from the cycle after data_ok until the next capture.
- Latency: best case is addr_ok in the issue cycle and data_ok one cycle later. d_stall is high for 2 cycles, then low in S_DONE.
- Slave contract: data_ok arrives no earlier than the cycle after addr_ok. A data_ok seen in S_REQ is ignored.
- At most one outstanding transaction; data_req is 0 in S_WAIT and S_DONE.
- S_DONE under longest_stall (e.g. instruction-side miss): the block stays in S_DONE with d_stall = 0 and data_req = 0, and rdata_r is held. The same M-stage access is not reissued.
- Core input stability: inputs are held stable while d_stall or longest_stall is high.
- data_sram_en falling while in S_WAIT (flush, e.g. exception): the transaction still completes. The block moves to S_DONE on data_ok and then to S_REQ once longest_stall is low; d_stall is 0 throughout.
- Back-to-back accesses: S_DONE -> S_REQ in the cycle the pipeline advances. The new access issues the following cycle, so there is no combinational loop from longest_stall to data_req.
- Reset mid-transaction: return to S_REQ immediately and abandon the outstanding transaction. The interface wrapper is reset by the same rst.

Decomposition:
- Shared package/header: state encodings (S_REQ = 2'd0, S_WAIT = 2'd1, S_DONE = 2'd2) and size codes (SIZE_B/SIZE_H/SIZE_W).
- One natural sub-module, wen_to_size: a pure combinational wen -> size/addr-align decoder. It is reused by the instruction-side bridge, which always uses SIZE_W.
- FSM and data register stay in the top module.

Test Plan:
- lw, addr 0x8000_0104: addr_ok in the issue cycle, data_ok +1 with data_rdata 0xDEADBEEF. Required: data_req for 1 cycle, data_size 2, data_addr 0x8000_0104, d_stall high 2 cycles, data_sram_rdata 0xDEADBEEF.
- sb, wen 0100, addr 0x8000_0012, wdata 0x00AB_0000. Required: data_wr 1, data_size 0, data_addr 0x8000_0012; d_stall drops after data_ok.
- lh, addr 0x8000_0006: addr_ok delayed 3 cycles. Required: data_req held 4 cycles, data_addr 0x8000_0004, size 2; no second request after addr_ok.
- Read completes while longest_stall is held 5 more cycles. Required: state S_DONE, d_stall 0, data_req 0 for all 5 cycles, rdata_r unchanged; the next access issues the cycle after longest_stall falls.
- Two consecutive sw accesses (0x10, 0x14). Required: exactly two data_req handshakes, in order, with correct wdata.
- rst asserted in S_WAIT. Required: state S_REQ, d_stall 0, and data_req 0 asynchronously. After release, a new lw issues normally.
